sha256_compress: RTL and testbench
==================================

// Module: sha256_compress
// PURPOSE
// - SHA-256 compression engine, directly downstream of message_scheduler.
// - Accepts one padded 512-bit block, loads it into the scheduler and consumes one W_t per cycle.
// - Runs 64 rounds on working vars a..h, then adds the result into chaining value H0..H7.
// - Multi-block messages chain through H; the digest is valid when done pulses.
// PARAMETERS
// - ROUNDS  64  rounds per block; 64 required for FIPS 180-4; smaller values are debug-only (wrong digest)
// PORTS
// - clk          in   1         clock, rising edge
// - n_rst        in   1         reset, asynchronous, active-low
// - start        in   1         request compression of block_in; honoured only in IDLE
// - first_block  in   1         sampled with start: 1 = init H from IV, 0 = chain from current H
// - block_in     in   [0:15][31:0]  padded block, word 0 = first big-endian word
// - sched_load   out  1         to message_scheduler.load
// - sched_data   out  [0:15][31:0]  to message_scheduler.data_in
// - w_in         in   32        from message_scheduler.data_out (W_t)
// - busy         out  1         high from the accepted start through FINAL
// - done         out  1         1-cycle pulse; digest valid from this cycle until next accepted start
// - digest       out  [0:7][31:0]   H0..H7, big-endian word order
// BEHAVIOUR
// - Reset: state=IDLE, t=0, a..h=0, H=IV, digest=0, busy=0, done=0. Reset mid-block aborts; no done.
// - States: IDLE -> ROUND -> FINAL -> IDLE.
// - Combinational outputs:
//   - sched_load = start & (state==IDLE).
//   - sched_data = block_in, driven combinationally (the scheduler registers it).
// - IDLE, start=1 (accept edge):
//   - a..h <= first_block ? IV : H; H <= IV when first_block=1; t <= 0; busy <= 1.
//   - Next state: ROUND.
// - ROUND: each cycle t, w_in = W_t (scheduler latency 1 after load).
//   - T1 = h + S1(e) + Ch(e,f,g) + K[t] + w_in; T2 = S0(a) + Maj(a,b,c).
//   - S1 = rotr6^rotr11^rotr25; S0 = rotr2^rotr13^rotr22.
//   - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2. All adds mod 2^32.
//   - t==ROUNDS-1 -> FINAL; else t++.
// - FINAL (1 cycle): H_i <= H_i + {a..h}_i mod 2^32; digest <= new H; done <= 1 on the same edge.
//   - Next state: IDLE; busy <= 0.
// - Latency: start accepted at edge E; rounds occupy 64 cycles; done high 66 cycles after E.
// - start while busy or in FINAL: ignored, sched_load stays 0. start in the cycle done is high: accepted.
// - first_block=0 after reset: chains from IV (reset value of H).
// - w_in is not sampled outside ROUND.
// CONFIGURATION
// - SHA224_EN defined: extra port mode_224 (in, 1), sampled with start when first_block=1.
//   - mode_224=1 selects the SHA-224 IV (c1059ed8 ... befa4fa4).
//   - digest[7] forced to 0 while the last accepted first_block start had mode_224=1.
// - SHA224_EN undefined: no mode_224 port; SHA-256 only.
// STRUCTURE
// - sha256_pkg:
//   - word_t (logic [31:0]), block_t ([0:15] word_t), hash_t ([0:7] word_t).
//   - K[0:63] constant table, IV256 / IV224 constants.
//   - state enum {IDLE, ROUND, FINAL}.
//   - functions rotr, big_sigma0, big_sigma1, ch, maj.
// - Sub-module sha256_round: purely combinational; (hash_t abcdefgh, word_t k, word_t w) -> hash_t next.
// - Top holds the FSM, round counter, H register, and the K lookup indexed by t.
// TESTING
// - Reset, then start with first_block=1, "abc" padded (w0=61626380, w15=00000018, others 0):
//   - done at E+66; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
// - Empty message (w0=80000000, rest 0):
//   - digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
// - "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", two blocks (second first_block=0):
//   - digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
// - Pulse start again at rounds 10 and 40 and in FINAL:
//   - no sched_load, busy stays 1, single done, digest unchanged vs. vector 1.
// - Assert n_rst at round 30, release, rerun "abc":
//   - done never pulses for the aborted block; correct "abc" digest after rerun.
// - SHA224_EN, mode_224=1, "abc":
//   - digest = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types, constants and round functions for the SHA-256 compression engine
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [0:15] block_t;
    typedef word_t [0:7]  hash_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam hash_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round over working variables a..h
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t abcdefgh,
    input  word_t k,
    input  word_t w,
    output hash_t next
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = abcdefgh[7] + big_sigma1(abcdefgh[4])
           + ch(abcdefgh[4], abcdefgh[5], abcdefgh[6]) + k + w;
        t2 = big_sigma0(abcdefgh[0]) + maj(abcdefgh[0], abcdefgh[1], abcdefgh[2]);
        next[0] = t1 + t2;
        next[1] = abcdefgh[0];
        next[2] = abcdefgh[1];
        next[3] = abcdefgh[2];
        next[4] = abcdefgh[3] + t1;
        next[5] = abcdefgh[4];
        next[6] = abcdefgh[5];
        next[7] = abcdefgh[6];
    end

endmodule

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - SHA-256 block compression FSM with chaining value; SHA224_EN adds mode_224
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   start,
    input  logic   first_block,
    input  block_t block_in,
`ifdef SHA224_EN
    input  logic   mode_224,
`endif
    output logic   sched_load,
    output block_t sched_data,
    input  word_t  w_in,
    output logic   busy,
    output logic   done,
    output hash_t  digest
);

    state_t     state;
    logic [5:0] t;
    hash_t      wv;
    hash_t      h_reg;
    hash_t      digest_r;
    hash_t      round_next;
    hash_t      h_new;
    hash_t      iv_sel;

    assign sched_load = start && (state == IDLE);
    assign sched_data = block_in;

    sha256_round u_round (
        .abcdefgh (wv),
        .k        (K[t]),
        .w        (w_in),
        .next     (round_next)
    );

    always_comb begin
        h_new = h_reg;
        for (int i = 0; i < 8; i++) begin
            h_new[i] = h_reg[i] + wv[i];
        end
    end

`ifdef SHA224_EN
    // Remembers the variant chosen by the most recent first block; it also masks H7 on the way out.
    logic m224;

    assign iv_sel = mode_224 ? IV224 : IV256;

    always_comb begin
        digest = digest_r;
        if (m224) begin
            digest[7] = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m224 <= 1'b0;
        end else if (sched_load && first_block) begin
            m224 <= mode_224;
        end
    end
`else
    assign iv_sel = IV256;
    assign digest = digest_r;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            t        <= '0;
            wv       <= '0;
            h_reg    <= IV256;
            digest_r <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        wv <= first_block ? iv_sel : h_reg;
                        if (first_block) begin
                            h_reg <= iv_sel;
                        end
                        t     <= '0;
                        busy  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    wv <= round_next;
                    if (t == 6'(ROUNDS - 1)) begin
                        state <= FINAL;
                    end else begin
                        t <= t + 6'd1;
                    end
                end
                FINAL: begin
                    h_reg    <= h_new;
                    digest_r <= h_new;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - directed self-checking bench for sha256_compress with a behavioural scheduler
module tb_sha256_compress;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic              first_block;
    logic [0:15][31:0] block_in;
    logic              sched_load;
    logic [0:15][31:0] sched_data;
    logic [31:0]       w_in;
    logic              busy;
    logic              done;
    logic [0:7][31:0]  digest;
`ifdef SHA224_EN
    logic              mode_224;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] BLK_TWO_A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO_B = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] DIG_224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

    sha256_compress dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .first_block (first_block),
        .block_in    (block_in),
`ifdef SHA224_EN
        .mode_224    (mode_224),
`endif
        .sched_load  (sched_load),
        .sched_data  (sched_data),
        .w_in        (w_in),
        .busy        (busy),
        .done        (done),
        .digest      (digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Message scheduler stand-in: loads on sched_load, W_t appears one cycle later and advances each cycle.
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0] win [0:15];
    assign w_in = win[0];

    always @(posedge clk) begin
        if (sched_load) begin
            for (int i = 0; i < 16; i++) win[i] <= sched_data[i];
        end else begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= (rr(win[14], 17) ^ rr(win[14], 19) ^ (win[14] >> 10)) + win[9]
                     + (rr(win[1], 7) ^ rr(win[1], 18) ^ (win[1] >> 3)) + win[0];
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 extra start pulses at rounds 10/40 and in FINAL, 2 reset at round 30
    task automatic run_block(input string tag, input logic [511:0] blk, input logic fb,
                             input int mode, input bit chk_dig, input logic [255:0] exp);
        int first_done = 0;
        int ndone = 0;
        @(negedge clk);
        block_in    = blk;
        first_block = fb;
        start       = 1'b1;
        #1;
        chk({tag, "_load"}, 512'(sched_load), 512'(1'b1));
        chk({tag, "_sdata"}, sched_data, blk);
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 33) n_rst = 1'b1;
            if (done) begin
                if (first_done == 0) first_done = k;
                ndone++;
            end
            if (mode == 0 && k == 1) chk({tag, "_busy_r0"}, 512'(busy), 512'(1'b1));
            if (mode == 1 && (k == 11 || k == 41 || k == 65)) begin
                start = 1'b1;
                #1;
                chk($sformatf("%s_noload_k%0d", tag, k), 512'(sched_load), 512'(1'b0));
                chk($sformatf("%s_busy_k%0d", tag, k), 512'(busy), 512'(1'b1));
            end
            if (mode == 2 && k == 31) begin
                n_rst = 1'b0;
                #1;
                chk({tag, "_rst_busy"}, 512'(busy), 512'(1'b0));
                chk({tag, "_rst_digest"}, 512'(digest), 512'(0));
            end
        end
        if (mode == 2) begin
            chk({tag, "_no_done"}, 512'(ndone), 512'(0));
        end else begin
            chk({tag, "_latency"}, 512'(first_done), 512'(66));
            chk({tag, "_ndone"}, 512'(ndone), 512'(1));
            chk({tag, "_busy_end"}, 512'(busy), 512'(1'b0));
            if (chk_dig) chk({tag, "_digest"}, 512'(digest), 512'(exp));
        end
    endtask

    initial begin
        n_rst       = 1'b0;
        start       = 1'b0;
        first_block = 1'b0;
        block_in    = '0;
`ifdef SHA224_EN
        mode_224    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", 512'(busy), 512'(1'b0));
        chk("reset_done", 512'(done), 512'(1'b0));
        chk("reset_digest", 512'(digest), 512'(0));
        chk("reset_load", 512'(sched_load), 512'(1'b0));
        n_rst = 1'b1;

        run_block("abc", BLK_ABC, 1'b1, 0, 1'b1, DIG_ABC);
        run_block("empty", BLK_EMPTY, 1'b1, 0, 1'b1, DIG_EMPTY);
        run_block("two_a", BLK_TWO_A, 1'b1, 0, 1'b0, '0);
        run_block("two_b", BLK_TWO_B, 1'b0, 0, 1'b1, DIG_TWO);
        run_block("inject", BLK_ABC, 1'b1, 1, 1'b1, DIG_ABC);
        run_block("abort", BLK_ABC, 1'b1, 2, 1'b0, '0);
        run_block("rerun_chain_iv", BLK_ABC, 1'b0, 0, 1'b1, DIG_ABC);
`ifdef SHA224_EN
        mode_224 = 1'b1;
        run_block("abc224", BLK_ABC, 1'b1, 0, 1'b1, DIG_224);
        mode_224 = 1'b0;
        run_block("abc256_again", BLK_ABC, 1'b1, 0, 1'b1, DIG_ABC);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
